// File: rtl/input_debounce_pair.sv
// Two independent debounce channels: 2-flop synchronizer, stability counter, change strobe.
// Optional feature macro DEBOUNCE_BYPASS_EN adds a `bypass` input that passes the synchronized level through.
module input_debounce_pair #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
`ifdef DEBOUNCE_BYPASS_EN
    input  logic bypass,
`endif
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_edge,
    output logic b_edge
);

    localparam int unsigned      NCH      = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] out;
    logic [NCH-1:0] strobe;

    assign raw    = {b_raw, a_raw};
    assign a      = out[0];
    assign b      = out[1];
    assign a_edge = strobe[0];
    assign b_edge = strobe[1];

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic             s1_q;
        logic             s2_q;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             out_q, out_d;
        logic             edge_q, edge_d;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                state_q <= IDLE;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                edge_q  <= 1'b0;
            end else begin
                s1_q    <= raw[ch];
                s2_q    <= s1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                edge_q  <= edge_d;
            end
        end

        // Accept s2 only after it has differed from out for STABLE_CYCLES consecutive edges.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
            edge_d  = 1'b0;
`ifdef DEBOUNCE_BYPASS_EN
            if (bypass) begin
                state_d = IDLE;
                cnt_d   = '0;
                out_d   = s2_q;
                edge_d  = (s2_q != out_q);
            end else begin
`endif
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (s2_q != out_q) begin
                        if (STABLE_CYCLES == 1) begin
                            out_d  = s2_q;
                            edge_d = 1'b1;
                        end else begin
                            state_d = COUNT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                COUNT: begin
                    if (s2_q == out_q) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        out_d   = s2_q;
                        edge_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
`ifdef DEBOUNCE_BYPASS_EN
            end
`endif
        end

        assign out[ch]    = out_q;
        assign strobe[ch] = edge_q;
    end

endmodule

// File: tb/tb_input_debounce_pair.sv
// Bench for input_debounce_pair: directed scenarios plus randomized run-length stimulus,
// checked against a sliding-window model of the synchronized input history.
module tb_input_debounce_pair;

    localparam int unsigned CNT_W         = 4;
    localparam int unsigned STABLE_CYCLES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic a, b, a_edge, b_edge;
`ifdef DEBOUNCE_BYPASS_EN
    logic bypass = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    input_debounce_pair #(
        .CNT_W        (CNT_W),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DEBOUNCE_BYPASS_EN
        .bypass(bypass),
`endif
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a     (a),
        .b     (b),
        .a_edge(a_edge),
        .b_edge(b_edge)
    );

    // Model: raw reaches the filter two edges late; out flips once the last
    // STABLE_CYCLES synchronized samples (since reset) all disagree with it.
    bit pipe  [2][2];
    bit win   [2][STABLE_CYCLES];
    int wlen  [2];
    bit mout  [2];
    bit medge [2];

    task automatic model_edge(input int ch, input bit rawv, input bit rstv);
        bit syn;
        bit all_diff;
        if (!rstv) begin
            pipe[ch][0] = 1'b0;
            pipe[ch][1] = 1'b0;
            wlen[ch]    = 0;
            mout[ch]    = 1'b0;
            medge[ch]   = 1'b0;
            return;
        end
        syn = pipe[ch][1];
        for (int i = STABLE_CYCLES - 1; i > 0; i--) win[ch][i] = win[ch][i-1];
        win[ch][0] = syn;
        if (wlen[ch] < STABLE_CYCLES) wlen[ch]++;
        all_diff = 1'b1;
        for (int i = 0; i < STABLE_CYCLES; i++)
            if (win[ch][i] == mout[ch]) all_diff = 1'b0;
        medge[ch] = 1'b0;
        if (wlen[ch] == STABLE_CYCLES && all_diff) begin
            mout[ch]  = ~mout[ch];
            medge[ch] = 1'b1;
        end
        pipe[ch][1] = pipe[ch][0];
        pipe[ch][0] = rawv;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        checks++;
        assert (a === mout[0]) else begin
            failures++;
            $error("FAIL a: observed %b expected %b at %0t", a, mout[0], $time);
        end
        checks++;
        assert (b === mout[1]) else begin
            failures++;
            $error("FAIL b: observed %b expected %b at %0t", b, mout[1], $time);
        end
        checks++;
        assert (a_edge === medge[0]) else begin
            failures++;
            $error("FAIL a_edge: observed %b expected %b at %0t", a_edge, medge[0], $time);
        end
        checks++;
        assert (b_edge === medge[1]) else begin
            failures++;
            $error("FAIL b_edge: observed %b expected %b at %0t", b_edge, medge[1], $time);
        end
    endtask

    // One clock: drive, model the rising edge, compare on the falling edge.
    task automatic step(input bit ra, input bit rb, input bit rn);
        a_raw = ra;
        b_raw = rb;
        rst_n = rn;
        @(posedge clk);
        model_edge(0, ra, rn);
        model_edge(1, rb, rn);
        @(negedge clk);
        check_outs();
    endtask

    task automatic hold(input bit ra, input bit rb, input int n);
        for (int i = 0; i < n; i++) step(ra, rb, 1'b1);
    endtask

    initial begin
        int lat;
        int lat_b;
        int pulses;
        int run_a, run_b;
        bit lvl_a, lvl_b, rn;

        // Reset with raw high: outputs stay low, then a rises on the 6th post-release edge.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("reset_a", int'(a), 0);
            chk("reset_a_edge", int'(a_edge), 0);
        end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1, 1'b1);
            if (a && lat == 0) lat = k;
        end
        chk("reset_release_lat", lat, STABLE_CYCLES + 2);

        // Clean rising step on A only.
        hold(1'b0, 1'b0, 12);
        lat = 0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, 1'b1);
            if (a && lat == 0) lat = k;
            if (a_edge) pulses++;
        end
        chk("clean_lat", lat, STABLE_CYCLES + 2);
        chk("clean_pulses", pulses, 1);
        chk("clean_b", int'(b), 0);

        // Glitch one cycle too short is rejected.
        hold(1'b0, 1'b0, 12);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            step(k < STABLE_CYCLES - 1, 1'b0, 1'b1);
            if (a_edge) pulses++;
        end
        chk("glitch3_pulses", pulses, 0);
        chk("glitch3_a", int'(a), 0);

        // Pulse of exactly STABLE_CYCLES passes, then the release passes too.
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            step(k < STABLE_CYCLES, 1'b0, 1'b1);
            if (a_edge) pulses++;
        end
        chk("glitch4_pulses", pulses, 2);
        chk("glitch4_a", int'(a), 0);

        // Bounce every clock, then settle high.
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step(k % 2 == 0, 1'b0, 1'b1);
            if (a_edge) pulses++;
        end
        chk("bounce_pulses", pulses, 0);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b0, 1'b1);
            if (a && lat == 0) lat = k;
        end
        chk("bounce_settle_lat", lat, STABLE_CYCLES + 2);

        // Both channels fall on the same clock from stable high.
        hold(1'b1, 1'b1, 12);
        lat = 0;
        lat_b = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b0, 1'b1);
            if (!a && a_edge && lat == 0) lat = k;
            if (!b && b_edge && lat_b == 0) lat_b = k;
        end
        chk("fall_a_lat", lat, STABLE_CYCLES + 2);
        chk("fall_b_lat", lat_b, STABLE_CYCLES + 2);

        // Reset while A is mid-count discards the partial count.
        hold(1'b0, 1'b0, 4);
        hold(1'b1, 1'b0, 4);
        step(1'b1, 1'b0, 1'b0);
        chk("midreset_a", int'(a), 0);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b0, 1'b1);
            if (a && lat == 0) lat = k;
        end
        chk("midreset_lat", lat, STABLE_CYCLES + 2);

        // Randomized run-length stimulus with occasional reset.
        run_a = 0;
        run_b = 0;
        lvl_a = 1'b0;
        lvl_b = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (run_a == 0) begin
                lvl_a = 1'($urandom_range(0, 1));
                run_a = int'($urandom_range(1, 8));
            end
            if (run_b == 0) begin
                lvl_b = 1'($urandom_range(0, 1));
                run_b = int'($urandom_range(1, 8));
            end
            rn = ($urandom_range(0, 149) != 0);
            step(lvl_a, lvl_b, rn);
            run_a--;
            run_b--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
